icache_dm_burst: RTL

- Parametrised direct-mapped instruction cache between the CPU fetch stage and the instruction ROM.
- Successor to the single-word fetch cache wrapper, with several additions:
  - configurable line count and words per line;
  - burst line refill from a fixed-latency ROM;
  - a pipelined valid/ready request port that sustains one hit per cycle;
  - a flush input;
  - hit/miss performance counters.
- Addresses are ROM word addresses; no byte addressing inside this block.

---
 rtl/icache_dm_burst.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/icache_dm_burst.sv
// Direct-mapped instruction cache with burst line refill from a fixed-latency ROM.
// Hits respond one cycle after acceptance. Misses stall until the whole line is refilled.
module icache_dm_burst #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int LINES   = 16,
   parameter int WORDS   = 4,
   parameter int ROM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   input  logic              flush,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              rom_rd,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_result,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt,
   output logic [1:0]        dbg_state
);

   localparam int OFF_W = $clog2(WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
   localparam int CW    = (WORDS > 1) ? OFF_W : 1;
   localparam int DEPTH = LINES * WORDS;
   localparam int DA_W  = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_REFILL = 2'd1, S_RESP = 2'd2} state_t;

   state_t              state_q, state_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_mem  [LINES];
   logic [DATA_W-1:0]   data_mem [DEPTH];
   logic [ADDR_W-1:0]   r_addr;
   logic [CW-1:0]       issue_cnt, cap_cnt;
   logic [ROM_LAT-1:0]  cap_pipe;

   logic [CW-1:0]       req_off, r_off;
   logic [IDX_W-1:0]    req_idx, r_idx;
   logic [TAG_W-1:0]    req_tag, r_tag;
   logic                lookup_hit, hit_acc, miss_acc, cap_now, last_issue, last_cap;

   function automatic logic [DA_W-1:0] mem_addr(input logic [IDX_W-1:0] idx,
                                                input logic [CW-1:0] off);
      return DA_W'(idx) * DA_W'(WORDS) + DA_W'(off);
   endfunction

   assign req_off = CW'(req_addr & ADDR_W'(WORDS - 1));
   assign req_idx = IDX_W'(req_addr >> OFF_W);
   assign req_tag = TAG_W'(req_addr >> (OFF_W + IDX_W));
   assign r_off   = CW'(r_addr & ADDR_W'(WORDS - 1));
   assign r_idx   = IDX_W'(r_addr >> OFF_W);
   assign r_tag   = TAG_W'(r_addr >> (OFF_W + IDX_W));

   // Request handshake: a request transfers in any cycle where req_valid && req_ready.
   // There is no response backpressure. A transfer yields exactly one resp_valid pulse, in order.
   assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
   assign hit_acc    = req_valid && req_ready && lookup_hit;
   assign miss_acc   = req_valid && req_ready && !lookup_hit;
   assign cap_now    = (state_q == S_REFILL) && cap_pipe[ROM_LAT-1];
   assign last_issue = (issue_cnt == CW'(WORDS - 1));
   assign last_cap   = cap_now && (cap_cnt == CW'(WORDS - 1));

   always_ff @(posedge iCLK) begin
      if (iRST) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (miss_acc) state_d = S_REFILL;
         S_REFILL: if (last_cap) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready = (state_q == S_IDLE) && !flush && !iRST;
      dbg_state = state_q;
   end

   // cap_pipe delays each issue strobe by ROM_LAT, marking cycles where rom_result is valid.
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         valid_q    <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         rom_rd     <= 1'b0;
         rom_addr   <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         r_addr     <= '0;
         issue_cnt  <= '0;
         cap_cnt    <= '0;
         cap_pipe   <= '0;
      end else begin
         resp_valid  <= 1'b0;
         cap_pipe[0] <= rom_rd;
         for (int i = 1; i < ROM_LAT; i++) cap_pipe[i] <= cap_pipe[i-1];

         if ((state_q == S_IDLE) && flush) valid_q <= '0;

         if (hit_acc) begin
            resp_valid <= 1'b1;
            resp_data  <= data_mem[mem_addr(req_idx, req_off)];
            hit_cnt    <= hit_cnt + CNT_W'(1);
         end

         if (miss_acc) begin
            miss_cnt  <= miss_cnt + CNT_W'(1);
            r_addr    <= req_addr;
            rom_rd    <= 1'b1;
            rom_addr  <= req_addr & ~ADDR_W'(WORDS - 1);
            issue_cnt <= '0;
            cap_cnt   <= '0;
         end

         if ((state_q == S_REFILL) && rom_rd) begin
            if (last_issue) begin
               rom_rd <= 1'b0;
            end else begin
               rom_addr  <= rom_addr + ADDR_W'(1);
               issue_cnt <= issue_cnt + CW'(1);
            end
         end

         if (cap_now) cap_cnt <= cap_cnt + CW'(1);

         // The last word arrives this cycle and has not yet reached data_mem.
         if (last_cap) begin
            valid_q[r_idx] <= 1'b1;
            resp_valid     <= 1'b1;
            resp_data      <= (r_off == CW'(WORDS - 1)) ? rom_result
                                                         : data_mem[mem_addr(r_idx, r_off)];
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (cap_now) data_mem[mem_addr(r_idx, cap_cnt)] <= rom_result;
      if (last_cap) tag_mem[r_idx] <= r_tag;
   end

endmodule
